// File: rtl/axi_pkg.sv
// Shared AXI read-path definitions: arbiter state encoding and AXI burst/size codes.
package axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_1B = 3'd0;
  localparam logic [2:0] SIZE_2B = 3'd1;
  localparam logic [2:0] SIZE_4B = 3'd2;
  localparam logic [2:0] SIZE_8B = 3'd3;

endpackage

// File: rtl/axi_read_arbiter_if.sv
// Bundle of the requester-side (s_*) and master-side (m_axi_*) read channels seen by
// axi_read_arbiter. The master modport is the arbiter's view; slave is the environment's.
//   s_ar*      per-requester AR channel (NREQ lanes), s_arready back per lane
//   s_r*       R data/last broadcast, s_rvalid/s_rready per lane
//   m_axi_*    single AXI4 read master port (AR + R)
interface axi_read_arbiter_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned NREQ   = 2
);

  logic [NREQ-1:0][ADDR_W-1:0] s_araddr;
  logic [NREQ-1:0][7:0]        s_arlen;
  logic [NREQ-1:0][2:0]        s_arsize;
  logic [NREQ-1:0][1:0]        s_arburst;
  logic [NREQ-1:0]             s_arvalid;
  logic [NREQ-1:0]             s_arready;
  logic [DATA_W-1:0]           s_rdata;
  logic                        s_rlast;
  logic [NREQ-1:0]             s_rvalid;
  logic [NREQ-1:0]             s_rready;

  logic [ADDR_W-1:0]           m_axi_araddr;
  logic [7:0]                  m_axi_arlen;
  logic [2:0]                  m_axi_arsize;
  logic [1:0]                  m_axi_arburst;
  logic                        m_axi_arvalid;
  logic                        m_axi_arready;
  logic [DATA_W-1:0]           m_axi_rdata;
  logic                        m_axi_rvalid;
  logic                        m_axi_rready;
  logic                        m_axi_rlast;

  modport master (
    input  s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid, s_rready,
    output s_arready, s_rdata, s_rlast, s_rvalid,
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid, m_axi_rready,
    input  m_axi_arready, m_axi_rdata, m_axi_rvalid, m_axi_rlast
  );

  modport slave (
    output s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid, s_rready,
    input  s_arready, s_rdata, s_rlast, s_rvalid,
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid, m_axi_rready,
    output m_axi_arready, m_axi_rdata, m_axi_rvalid, m_axi_rlast
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way combinational round-robin pick.
//   req        request vector
//   last_grant index of the previous winner (lowest priority this round)
//   gnt        one-hot grant, zero when nothing requests
//   idx        winner index (meaningful only when valid)
//   valid      some request is present
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt,
  output logic       idx,
  output logic       valid
);

  logic pref;

  always_comb begin
    pref  = ~last_grant;
    valid = |req;
    idx   = req[pref] ? pref : last_grant;
    gnt   = valid ? (2'b01 << idx) : 2'b00;
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI4 read master port between two requesters (0 = fetch, 1 = LSU), one whole
// burst at a time, round-robin. The winning AR is registered, then R beats are steered back
// to the owner until the rlast handshake.
//   clk, reset  clock and async active-low reset
//   bus         requester and master read channels (master modport)
//   grant_id    current or most recent owner
//   busy        arbiter not idle
//   proto_err   sticky beat-count / rlast mismatch
module axi_read_arbiter
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned NREQ   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  axi_read_arbiter_if.master   bus,
  output logic                 grant_id,
  output logic                 busy,
  output logic                 proto_err
);

  arb_state_e        state_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [7:0]        arlen_q;
  logic [2:0]        arsize_q;
  logic [1:0]        arburst_q;
  logic              arvalid_q;
  logic              grant_q;
  logic              last_grant_q;
  logic [8:0]        beat_cnt_q;
  logic              proto_err_q;

  logic [1:0]        arb_gnt;
  logic              arb_idx;
  logic              arb_valid;
  logic              in_idle;
  logic              in_data;
  logic              beat_hs;
  logic [NREQ-1:0]   rvalid_steer;
  logic [DATA_W-1:0] rdata_gated;

  rr_arbiter2 u_rr (
    .req        (bus.s_arvalid),
    .last_grant (last_grant_q),
    .gnt        (arb_gnt),
    .idx        (arb_idx),
    .valid      (arb_valid)
  );

  always_comb begin
    in_idle      = (state_q == IDLE);
    in_data      = (state_q == DATA);
    beat_hs      = in_data && bus.m_axi_rvalid && bus.s_rready[grant_q];
    rvalid_steer = '0;
    if (in_data) rvalid_steer[grant_q] = bus.m_axi_rvalid;
    rdata_gated  = in_data ? bus.m_axi_rdata : '0;
  end

  // s_arready is gated by reset so every output reads 0 while reset is held.
  assign bus.s_arready     = (in_idle && reset) ? arb_gnt : '0;
  assign bus.s_rvalid      = rvalid_steer;
  assign bus.s_rdata       = rdata_gated;
  assign bus.s_rlast       = in_data & bus.m_axi_rlast;
  assign bus.m_axi_rready  = in_data & bus.s_rready[grant_q];
  assign bus.m_axi_araddr  = araddr_q;
  assign bus.m_axi_arlen   = arlen_q;
  assign bus.m_axi_arsize  = arsize_q;
  assign bus.m_axi_arburst = arburst_q;
  assign bus.m_axi_arvalid = arvalid_q;

  assign grant_id  = grant_q;
  assign busy      = !in_idle;
  assign proto_err = proto_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      araddr_q     <= '0;
      arlen_q      <= '0;
      arsize_q     <= '0;
      arburst_q    <= '0;
      arvalid_q    <= 1'b0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;  // port 0 wins the first contest
      beat_cnt_q   <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_valid) begin
            araddr_q   <= bus.s_araddr[arb_idx];
            arlen_q    <= bus.s_arlen[arb_idx];
            arsize_q   <= bus.s_arsize[arb_idx];
            arburst_q  <= bus.s_arburst[arb_idx];
            grant_q    <= arb_idx;
            beat_cnt_q <= '0;
            arvalid_q  <= 1'b1;
            state_q    <= ADDR;
          end
        end
        ADDR: begin
          if (bus.m_axi_arready) begin
            arvalid_q <= 1'b0;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (beat_hs) begin
            beat_cnt_q <= beat_cnt_q + 9'd1;
            if (bus.m_axi_rlast) begin
              if (beat_cnt_q != {1'b0, arlen_q}) proto_err_q <= 1'b1;
              last_grant_q <= grant_q;
              state_q      <= IDLE;
            end else if (beat_cnt_q >= {1'b0, arlen_q}) begin
              // Beat index arlen must carry rlast; keep draining until it shows up.
              proto_err_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
